// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register; handles decode stalls, redirects and PC faults.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 4096,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] RomAddr,
  input  logic [31:0] RomData,
  input  logic        Stall,
  input  logic        JumpEn,
  input  logic [31:0] JumpAddr,
  output logic [31:0] InstOut,
  output logic [31:0] PcOut,
  output logic        ValidOut,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  typedef enum logic {RUN, HALT} state_t;

  // Upper bound kept at 33 bits so ROM_DEPTH*4 == 2^32 cannot overflow.
  localparam logic [32:0] PC_LIMIT = 33'(ROM_DEPTH) << 2;

  state_t      state;
  logic [31:0] pc;
  logic        pc_bad;

  assign RomAddr = pc;

  always_comb begin
    pc_bad = (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc         <= RESET_PC;
      state      <= RUN;
      InstOut    <= NOP_INST;
      PcOut      <= '0;
      ValidOut   <= 1'b0;
      FetchFault <= 1'b0;
      FetchCount <= '0;
    end else if (state == RUN) begin
      if (JumpEn) begin
        // Target is validated only when it is actually fetched.
        pc       <= JumpAddr;
        InstOut  <= NOP_INST;
        PcOut    <= '0;
        ValidOut <= 1'b0;
      end else if (!Stall) begin
        if (pc_bad) begin
          // PC is left untouched so the faulting address stays observable.
          state      <= HALT;
          FetchFault <= 1'b1;
          InstOut    <= NOP_INST;
          PcOut      <= '0;
          ValidOut   <= 1'b0;
        end else begin
          InstOut    <= RomData;
          PcOut      <= pc;
          ValidOut   <= 1'b1;
          pc         <= pc + 32'd4;
          FetchCount <= FetchCount + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stall/redirect/reset traffic, all checked against a behavioural model.
module tb_instr_fetch;

  localparam int unsigned ROM_DEPTH = 4096;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] RomAddr;
  logic [31:0] RomData;
  logic        Stall;
  logic        JumpEn;
  logic [31:0] JumpAddr;
  logic [31:0] InstOut;
  logic [31:0] PcOut;
  logic        ValidOut;
  logic        FetchFault;
  logic [31:0] FetchCount;

  logic [31:0] rom_key = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pcout, m_count;
  logic        m_valid, m_fault, m_halted;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_DEPTH(ROM_DEPTH),
    .NOP_INST (NOP)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .RomAddr   (RomAddr),
    .RomData   (RomData),
    .Stall     (Stall),
    .JumpEn    (JumpEn),
    .JumpAddr  (JumpAddr),
    .InstOut   (InstOut),
    .PcOut     (PcOut),
    .ValidOut  (ValidOut),
    .FetchFault(FetchFault),
    .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr, input logic [31:0] key);
    return (32'h1000_0000 + (addr >> 2)) ^ key;
  endfunction

  always_comb RomData = rom_word(RomAddr, rom_key);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) >= longint'(ROM_DEPTH) * 4);
  endfunction

  // Apply the rules for one rising edge, given the inputs presented before it.
  task automatic model_edge();
    if (Rst) begin
      m_pc = '0; m_halted = 0; m_inst = NOP; m_pcout = '0;
      m_valid = 0; m_fault = 0; m_count = '0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (JumpEn) begin
      m_pc = JumpAddr; m_inst = NOP; m_pcout = '0; m_valid = 0;
    end else if (Stall) begin
      // hold
    end else if (addr_bad(m_pc)) begin
      m_halted = 1; m_fault = 1; m_inst = NOP; m_pcout = '0; m_valid = 0;
    end else begin
      m_inst  = rom_word(m_pc, rom_key);
      m_pcout = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_count = m_count + 1;
    end
  endtask

  task automatic check_model(input string ctx);
    check({ctx, ".RomAddr"},    RomAddr,           m_pc);
    check({ctx, ".InstOut"},    InstOut,           m_inst);
    check({ctx, ".PcOut"},      PcOut,             m_pcout);
    check({ctx, ".ValidOut"},   {31'd0, ValidOut}, {31'd0, m_valid});
    check({ctx, ".FetchFault"}, {31'd0, FetchFault}, {31'd0, m_fault});
    check({ctx, ".FetchCount"}, FetchCount,        m_count);
  endtask

  task automatic tick(input bit rst, input bit stall, input bit jen,
                      input logic [31:0] jaddr, input string ctx);
    Rst = rst; Stall = stall; JumpEn = jen; JumpAddr = jaddr;
    model_edge();
    @(posedge Clk);
    #1;
    check_model(ctx);
  endtask

  initial begin
    Rst = 1; Stall = 0; JumpEn = 0; JumpAddr = '0;

    // Reset and free run
    tick(1, 0, 0, 0, "reset");
    check("rst.InstOut", InstOut, 32'h0000_0013);
    check("rst.Valid",   {31'd0, ValidOut}, 32'd0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, "run");
    check("run3.InstOut", InstOut,    32'h1000_0002);
    check("run3.PcOut",   PcOut,      32'h0000_0008);
    check("run3.Valid",   {31'd0, ValidOut}, 32'd1);
    check("run3.Count",   FetchCount, 32'd3);

    // Stall while PcOut=4
    tick(1, 0, 0, 0, "reset2");
    tick(0, 0, 0, 0, "pre_stall");
    tick(0, 0, 0, 0, "pre_stall");
    check("stall.pre.PcOut", PcOut, 32'h4);
    tick(0, 1, 0, 0, "stall");
    tick(0, 1, 0, 0, "stall");
    check("stall.PcOut", PcOut,      32'h4);
    check("stall.Inst",  InstOut,    32'h1000_0001);
    check("stall.Count", FetchCount, 32'd2);
    tick(0, 0, 0, 0, "post_stall");
    check("post_stall.PcOut", PcOut,   32'h8);
    check("post_stall.Inst",  InstOut, 32'h1000_0002);

    // Jump overriding stall
    tick(0, 1, 1, 32'h100, "jump_stall");
    check("jump.Valid", {31'd0, ValidOut}, 32'd0);
    check("jump.Inst",  InstOut, 32'h13);
    tick(0, 0, 0, 0, "jump_target");
    check("jump.PcOut",  PcOut, 32'h100);
    check("jump.Valid2", {31'd0, ValidOut}, 32'd1);
    check("jump.Inst2",  InstOut, 32'h1000_0040);

    // Run off the end of the ROM
    tick(0, 0, 1, 32'h3FF8, "to_end");
    tick(0, 0, 0, 0, "end");
    tick(0, 0, 0, 0, "end");
    check("last.PcOut", PcOut, 32'h3FFC);
    check("last.Valid", {31'd0, ValidOut}, 32'd1);
    tick(0, 0, 0, 0, "oob");
    check("oob.Fault", {31'd0, FetchFault}, 32'd1);
    check("oob.Valid", {31'd0, ValidOut}, 32'd0);
    tick(0, 0, 1, 32'h0, "halt_jump");
    tick(0, 0, 0, 0, "halt_hold");
    check("halt.RomAddr", RomAddr, 32'h4000);
    check("halt.Fault",   {31'd0, FetchFault}, 32'd1);

    // Misaligned jump target, then recovery by reset
    tick(0, 0, 1, 32'h0, "reset_prep");
    tick(1, 1, 1, 32'h55, "reset_in_halt");
    tick(0, 0, 1, 32'h102, "mis_jump");
    tick(0, 0, 0, 0, "mis_fault");
    check("mis.Fault",   {31'd0, FetchFault}, 32'd1);
    check("mis.RomAddr", RomAddr, 32'h102);
    tick(1, 0, 0, 0, "mis_reset");
    check("mis.rst.Fault", {31'd0, FetchFault}, 32'd0);
    check("mis.rst.Count", FetchCount, 32'd0);
    tick(0, 0, 0, 0, "mis_resume");
    check("mis.resume.PcOut", PcOut, 32'h0);
    check("mis.resume.Valid", {31'd0, ValidOut}, 32'd1);

    // Random traffic
    rom_key = $urandom;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 85) tgt = {18'd0, 12'($urandom_range(0, ROM_DEPTH - 1)), 2'b00};
      else if (r < 92) tgt = 32'h3FF0 + 32'($urandom_range(0, 3)) * 4;
      else tgt = $urandom;
      tick($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 10, tgt, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
